// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and default sizes for the round-robin sum/parity adder arbiter.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between the requesting blocks (master) and the arbiter (slave).
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_parity;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_parity, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_parity, busy
    );

endinterface

// File: rtl/adder_share_arbiter_sum_parity_unit.sv
// Registered (a+b) mod 2^WIDTH and its XOR parity; loads when load_i is high.
module sum_parity_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             parity_o
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             parity_q;

    // Carry-out is deliberately dropped; parity covers the truncated sum only.
    assign sum_d = a_i + b_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            parity_q <= 1'b0;
        end else if (load_i) begin
            sum_q    <= sum_d;
            parity_q <= ^sum_d;
        end
    end

    assign sum_o    = sum_q;
    assign parity_o = parity_q;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered sum/parity unit between NUM_REQ requesters.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t       state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rsp_valid_q;

    logic [ID_W:0]        pick;
    logic [ID_W-1:0]      pick_id;
    logic                 grant_vld;
    logic [NUM_REQ-1:0]   req_ready_d;
    logic [WIDTH-1:0]     a_sel;
    logic [WIDTH-1:0]     b_sel;
    logic [ID_W-1:0]      rr_ptr_d;

    // Returns {found, id}: first valid requester scanning ptr, ptr+1, ... mod NUM_REQ.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    assign pick      = rr_pick(bus.req_valid, rr_ptr_q);
    assign pick_id   = pick[ID_W-1:0];
    assign grant_vld = (state_q == IDLE) && pick[ID_W];
    assign rr_ptr_d  = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        req_ready_d = '0;
        a_sel       = '0;
        b_sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                req_ready_d[i] = grant_vld;
                a_sel          = bus.req_a[i*WIDTH +: WIDTH];
                b_sel          = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        a_q     <= a_sel;
                        b_q     <= b_sel;
                        id_q    <= pick_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    sum_parity_unit #(.WIDTH(WIDTH)) u_unit (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_q == EXEC),
        .a_i      (a_q),
        .b_i      (b_q),
        .sum_o    (bus.rsp_sum),
        .parity_o (bus.rsp_parity)
    );

    assign bus.req_ready = req_ready_d;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: vector table plus hand-written corner sequences.
module tb_adder_share_arbiter;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    adder_share_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

    adder_share_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int idx, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid[idx]      = 1'b1;
        bus.req_a[idx*8 +: 8]   = a;
        bus.req_b[idx*8 +: 8]   = b;
    endtask

    task automatic wait_grant(output logic [3:0] g);
        #1;
        g = bus.req_ready;
        for (int n = 0; n < 20 && g == 4'b0; n++) begin
            @(negedge clk);
            #1;
            g = bus.req_ready;
        end
    endtask

    // Called at the negedge inside EXEC; checks RESP then the return to IDLE.
    task automatic finish_rsp(input logic [1:0] id, input logic [7:0] sum, input logic par);
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_sum", 32'(bus.rsp_sum), 32'(sum));
        chk("rsp_parity", 32'(bus.rsp_parity), 32'(par));
        @(negedge clk);
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] g;
    logic [7:0] exp_sum;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{1, 8'h01, 8'h01, 8'h02, 1'b1};
        vecs[1] = '{0, 8'hFF, 8'h01, 8'h00, 1'b0};
        vecs[2] = '{0, 8'h0A, 8'h01, 8'h0B, 1'b1};
        vecs[3] = '{3, 8'h80, 8'h80, 8'h00, 1'b0};
        vecs[4] = '{2, 8'h7F, 8'h01, 8'h80, 1'b1};
        vecs[5] = '{1, 8'h3C, 8'h0F, 8'h4B, 1'b0};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requests from the vector table.
        for (int v = 0; v < 6; v++) begin
            drive_req(vecs[v].idx, vecs[v].a, vecs[v].b);
            wait_grant(g);
            chk("grant", 32'(g), 32'(4'b0001 << vecs[v].idx));
            @(negedge clk);
            bus.req_valid = '0;
            chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("exec_busy", 32'(bus.busy), 32'd1);
            chk("exec_req_ready", 32'(bus.req_ready), 32'd0);
            finish_rsp(2'(vecs[v].idx), vecs[v].sum, vecs[v].par);
            $display("[TB] vec %0d req %0d a=%02h b=%02h -> sum=%02h", v, vecs[v].idx,
                     vecs[v].a, vecs[v].b, bus.rsp_sum);
        end

        // All four held valid: round-robin order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) drive_req(i, 8'(8'h11 * i), 8'h01);
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk("rr_grant", 32'(g), 32'(4'b0001 << (k % 4)));
            @(negedge clk);
            if (k == 4) bus.req_valid = '0;
            @(negedge clk);
            exp_sum = 8'(8'h11 * (k % 4) + 1);
            chk("rr_rsp_id", 32'(bus.rsp_id), 32'(k % 4));
            chk("rr_rsp_sum", 32'(bus.rsp_sum), 32'(exp_sum));
            $display("[TB] rr grant %0d id=%0d sum=%02h", k, bus.rsp_id, bus.rsp_sum);
            @(negedge clk);
        end
        chk("rr_idle", 32'(bus.busy), 32'd0);

        // Backpressure: response held for 5 cycles.
        bus.rsp_ready = 1'b0;
        drive_req(2, 8'h05, 8'h06);
        wait_grant(g);
        chk("bp_grant", 32'(g), 32'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd2);
            chk("bp_rsp_sum", 32'(bus.rsp_sum), 32'h0B);
            chk("bp_rsp_parity", 32'(bus.rsp_parity), 32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_busy", 32'(bus.busy), 32'd0);
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        $display("[TB] backpressure release busy=%0d", bus.busy);

        // Reset during EXEC drops the op; next grant starts from requester 0.
        drive_req(3, 8'h21, 8'h12);
        wait_grant(g);
        chk("rm_grant", 32'(g), 32'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_busy", 32'(bus.busy), 32'd0);
        chk("rm_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rm_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rm_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        chk("rm_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rm_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        for (int i = 0; i < 4; i++) drive_req(i, 8'h30, 8'(i));
        wait_grant(g);
        chk("rm_first_grant", 32'(g), 32'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        finish_rsp(2'd0, 8'h30, 1'b0);
        $display("[TB] post-reset grant id=0");

        // Late request arriving during RESP waits for the next IDLE.
        drive_req(0, 8'h44, 8'h01);
        wait_grant(g);
        chk("late_grant0", 32'(g), 32'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        drive_req(2, 8'h0F, 8'h0F);
        #1;
        chk("late_resp_ready", 32'(bus.req_ready), 32'd0);
        chk("late_resp_sum", 32'(bus.rsp_sum), 32'h45);
        @(negedge clk);
        #1;
        chk("late_idle_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        finish_rsp(2'd2, 8'h1E, 1'b0);
        $display("[TB] late request id=2 sum=1e");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
